// File: rtl/spatz_pkg.sv
// Response formats and widths shared by the Spatz completion stage.
package spatz_pkg;

    localparam int unsigned ELEN            = 32;
    localparam int unsigned GPRWidth        = 5;
    localparam int unsigned NrParallelInstr = 8;

    typedef logic [$clog2(NrParallelInstr)-1:0] spatz_id_t;

    typedef struct packed {
        spatz_id_t           id;
        logic [ELEN-1:0]     result;
        logic [GPRWidth-1:0] rd;
        logic                wb;
    } vfu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
        logic      exc;
    } vlsu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
    } vsldu_rsp_t;

endpackage

// File: rtl/spatz_rsp_arbiter.sv
// Retires one VFU/VLSU/VSLDU response per cycle (round-robin) and buffers VFU scalar writebacks.
// Optional macro SPATZ_RSP_EXC_EN forwards the VLSU exception flag on retire_exc_o.
module spatz_rsp_arbiter
    import spatz_pkg::*;
#(
    parameter int unsigned WbFifoDepth = 2,
    parameter type rsp_vfu_t   = spatz_pkg::vfu_rsp_t,
    parameter type rsp_vlsu_t  = spatz_pkg::vlsu_rsp_t,
    parameter type rsp_vsldu_t = spatz_pkg::vsldu_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vfu_rsp_valid_i,
    input  rsp_vfu_t            vfu_rsp_i,
    output logic                vfu_rsp_ready_o,
    input  logic                vlsu_rsp_valid_i,
    input  rsp_vlsu_t           vlsu_rsp_i,
    output logic                vlsu_rsp_ready_o,
    input  logic                vsldu_rsp_valid_i,
    input  rsp_vsldu_t          vsldu_rsp_i,
    output logic                vsldu_rsp_ready_o,
    output logic                retire_valid_o,
    output spatz_id_t           retire_id_o,
    output logic                retire_exc_o,
    input  logic                retire_ready_i,
    output logic                wb_valid_o,
    output logic [ELEN-1:0]     wb_data_o,
    output logic [GPRWidth-1:0] wb_rd_o,
    input  logic                wb_ready_i
);

    localparam int unsigned PtrW = (WbFifoDepth > 1) ? $clog2(WbFifoDepth) : 1;
    localparam int unsigned MemN = 1 << PtrW;
    localparam int unsigned CntW = $clog2(WbFifoDepth + 1);

    typedef struct packed {
        logic [ELEN-1:0]     data;
        logic [GPRWidth-1:0] rd;
    } wb_entry_t;

    logic [1:0]      rr_q;
    logic            ret_valid_q;
    spatz_id_t       ret_id_q;
    wb_entry_t       mem_q [MemN];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic            fifo_full;
    logic            can_load;
    logic [2:0]      elig;
    logic            found;
    logic [1:0]      gnt_idx;
    logic            grant;
    spatz_id_t       gnt_id;
    logic [1:0]      rr_next;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(WbFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign fifo_full = (cnt_q == CntW'(WbFifoDepth));
    // A VFU response carrying a writeback must not be taken while the FIFO has no room.
    assign elig      = {vsldu_rsp_valid_i, vlsu_rsp_valid_i,
                        vfu_rsp_valid_i & (~vfu_rsp_i.wb | ~fifo_full)};
    assign can_load  = ~ret_valid_q | retire_ready_i;

    always_comb begin
        found   = 1'b0;
        gnt_idx = 2'd0;
        case (rr_q)
            2'd1: begin
                if (elig[1])      begin found = 1'b1; gnt_idx = 2'd1; end
                else if (elig[2]) begin found = 1'b1; gnt_idx = 2'd2; end
                else if (elig[0]) begin found = 1'b1; gnt_idx = 2'd0; end
            end
            2'd2: begin
                if (elig[2])      begin found = 1'b1; gnt_idx = 2'd2; end
                else if (elig[0]) begin found = 1'b1; gnt_idx = 2'd0; end
                else if (elig[1]) begin found = 1'b1; gnt_idx = 2'd1; end
            end
            default: begin
                if (elig[0])      begin found = 1'b1; gnt_idx = 2'd0; end
                else if (elig[1]) begin found = 1'b1; gnt_idx = 2'd1; end
                else if (elig[2]) begin found = 1'b1; gnt_idx = 2'd2; end
            end
        endcase
    end

    always_comb begin
        gnt_id = vsldu_rsp_i.id;
        case (gnt_idx)
            2'd0:    gnt_id = vfu_rsp_i.id;
            2'd1:    gnt_id = vlsu_rsp_i.id;
            default: gnt_id = vsldu_rsp_i.id;
        endcase
    end

    // Reset gates the grant so no ready is seen and nothing is captured while rst_i is high.
    assign grant   = found & can_load & ~rst_i;
    assign rr_next = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

    assign vfu_rsp_ready_o   = grant & (gnt_idx == 2'd0);
    assign vlsu_rsp_ready_o  = grant & (gnt_idx == 2'd1);
    assign vsldu_rsp_ready_o = grant & (gnt_idx == 2'd2);

    assign push = vfu_rsp_ready_o & vfu_rsp_i.wb;
    assign pop  = (cnt_q != '0) & wb_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= 2'd0;
            ret_valid_q <= 1'b0;
            ret_id_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (grant) begin
                rr_q        <= rr_next;
                ret_valid_q <= 1'b1;
                ret_id_q    <= gnt_id;
            end else if (retire_ready_i) begin
                ret_valid_q <= 1'b0;
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= '{data: vfu_rsp_i.result, rd: vfu_rsp_i.rd};
    end

`ifdef SPATZ_RSP_EXC_EN
    logic ret_exc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)      ret_exc_q <= 1'b0;
        else if (grant) ret_exc_q <= (gnt_idx == 2'd1) & vlsu_rsp_i.exc;
    end

    assign retire_exc_o = ret_exc_q;
`else
    logic unused_vlsu_exc;

    assign unused_vlsu_exc = vlsu_rsp_i.exc;
    assign retire_exc_o    = 1'b0;
`endif

    assign retire_valid_o = ret_valid_q;
    assign retire_id_o    = ret_id_q;

    // Payload is masked while empty so the outputs read zero after reset.
    assign wb_valid_o = (cnt_q != '0);
    assign wb_data_o  = wb_valid_o ? mem_q[rd_ptr_q].data : '0;
    assign wb_rd_o    = wb_valid_o ? mem_q[rd_ptr_q].rd   : '0;

endmodule

// File: tb/tb_spatz_rsp_arbiter.sv
// Directed vector bench for spatz_rsp_arbiter (default WbFifoDepth=2).
module tb_spatz_rsp_arbiter;
    import spatz_pkg::*;

`ifdef SPATZ_RSP_EXC_EN
    localparam logic EXC_ON = 1'b1;
`else
    localparam logic EXC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        vfu_v, vlsu_v, vsldu_v;
    vfu_rsp_t    vfu_rsp;
    vlsu_rsp_t   vlsu_rsp;
    vsldu_rsp_t  vsldu_rsp;
    logic        vfu_rdy, vlsu_rdy, vsldu_rdy;
    logic        ret_v, ret_exc, ret_rdy;
    spatz_id_t   ret_id;
    logic        wb_v, wb_rdy;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int n_cmp  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    spatz_rsp_arbiter dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .vfu_rsp_valid_i   (vfu_v),
        .vfu_rsp_i         (vfu_rsp),
        .vfu_rsp_ready_o   (vfu_rdy),
        .vlsu_rsp_valid_i  (vlsu_v),
        .vlsu_rsp_i        (vlsu_rsp),
        .vlsu_rsp_ready_o  (vlsu_rdy),
        .vsldu_rsp_valid_i (vsldu_v),
        .vsldu_rsp_i       (vsldu_rsp),
        .vsldu_rsp_ready_o (vsldu_rdy),
        .retire_valid_o    (ret_v),
        .retire_id_o       (ret_id),
        .retire_exc_o      (ret_exc),
        .retire_ready_i    (ret_rdy),
        .wb_valid_o        (wb_v),
        .wb_data_o         (wb_data),
        .wb_rd_o           (wb_rd),
        .wb_ready_i        (wb_rdy)
    );

    typedef struct {
        logic        rst;
        logic        vv;  logic [2:0] vid; logic vwb; logic [4:0] vrd; logic [31:0] vres;
        logic        lv;  logic [2:0] lid; logic lexc;
        logic        sv;  logic [2:0] sid;
        logic        rr;  logic wr;
        logic [2:0]  e_rdy;                  // {vsldu, vlsu, vfu}, checked before the edge
        logic        e_rv; logic [2:0] e_rid; logic e_rexc;
        logic        e_wv; logic [4:0] e_wrd; logic [31:0] e_wdata;
        logic [1:0]  e_rrq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_, input logic vv, input logic [2:0] vid, input logic vwb,
                       input logic [4:0] vrd, input logic [31:0] vres,
                       input logic lv, input logic [2:0] lid, input logic lexc,
                       input logic sv, input logic [2:0] sid, input logic rr, input logic wr,
                       input logic [2:0] e_rdy, input logic e_rv, input logic [2:0] e_rid,
                       input logic e_rexc, input logic e_wv, input logic [4:0] e_wrd,
                       input logic [31:0] e_wdata, input logic [1:0] e_rrq);
        vec_t v;
        v.rst = rst_; v.vv = vv; v.vid = vid; v.vwb = vwb; v.vrd = vrd; v.vres = vres;
        v.lv = lv; v.lid = lid; v.lexc = lexc; v.sv = sv; v.sid = sid; v.rr = rr; v.wr = wr;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_rid = e_rid; v.e_rexc = e_rexc;
        v.e_wv = e_wv; v.e_wrd = e_wrd; v.e_wdata = e_wdata; v.e_rrq = e_rrq;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", k, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        vfu_v = v.vv; vfu_rsp.id = v.vid; vfu_rsp.wb = v.vwb; vfu_rsp.rd = v.vrd; vfu_rsp.result = v.vres;
        vlsu_v = v.lv; vlsu_rsp.id = v.lid; vlsu_rsp.exc = v.lexc;
        vsldu_v = v.sv; vsldu_rsp.id = v.sid;
        ret_rdy = v.rr; wb_rdy = v.wr;
    endtask

    task automatic idle();
        rst = 1'b0; vfu_v = 1'b0; vlsu_v = 1'b0; vsldu_v = 1'b0;
        vfu_rsp = '0; vlsu_rsp = '0; vsldu_rsp = '0; ret_rdy = 1'b1; wb_rdy = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        //   rst vv id wb rd  result        lv id exc      sv id  rr wr  rdy     rv id exc    wv rd  data          rrq
        add(1, 1, 1, 1, 1, 32'h1,          1, 2, 0,       1, 3,  1, 1, 3'b000, 0, 0, 0,      0, 0,  32'h0,        0); // 0 reset
        add(0, 1, 2, 1, 5, 32'hDEADBEEF,   0, 0, 0,       0, 0,  1, 0, 3'b001, 1, 2, 0,      1, 5,  32'hDEADBEEF, 1); // 1 vfu wb
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       1, 6,  1, 1, 3'b100, 1, 6, 0,      0, 0,  32'h0,        0); // 2 vsldu, drain
        add(0, 1, 0, 0, 0, 32'h0,          1, 1, 0,       1, 3,  1, 1, 3'b001, 1, 0, 0,      0, 0,  32'h0,        1); // 3 all valid
        add(0, 0, 0, 0, 0, 32'h0,          1, 1, 0,       1, 3,  1, 1, 3'b010, 1, 1, 0,      0, 0,  32'h0,        2); // 4
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       1, 3,  1, 1, 3'b100, 1, 3, 0,      0, 0,  32'h0,        0); // 5
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 3, 0,      0, 0,  32'h0,        0); // 6
        add(0, 0, 0, 0, 0, 32'h0,          1, 1, 0,       0, 0,  0, 1, 3'b010, 1, 1, 0,      0, 0,  32'h0,        2); // 7 backpressure
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       1, 4,  0, 1, 3'b000, 1, 1, 0,      0, 0,  32'h0,        2); // 8
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       1, 4,  0, 1, 3'b000, 1, 1, 0,      0, 0,  32'h0,        2); // 9
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       1, 4,  1, 1, 3'b100, 1, 4, 0,      0, 0,  32'h0,        0); // 10
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 4, 0,      0, 0,  32'h0,        0); // 11
        add(0, 1, 1, 1, 7, 32'h11111111,   0, 0, 0,       0, 0,  1, 0, 3'b001, 1, 1, 0,      1, 7,  32'h11111111, 1); // 12 fifo fill
        add(0, 1, 2, 1, 8, 32'h22222222,   0, 0, 0,       0, 0,  1, 0, 3'b001, 1, 2, 0,      1, 7,  32'h11111111, 1); // 13 full
        add(0, 1, 3, 1, 9, 32'h33333333,   0, 0, 0,       1, 3,  1, 0, 3'b100, 1, 3, 0,      1, 7,  32'h11111111, 0); // 14 vfu stalled
        add(0, 1, 3, 1, 9, 32'h33333333,   0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 3, 0,      1, 8,  32'h22222222, 0); // 15 pop, no push
        add(0, 1, 3, 1, 9, 32'h33333333,   0, 0, 0,       0, 0,  1, 0, 3'b001, 1, 3, 0,      1, 8,  32'h22222222, 1); // 16 third accepted
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 3, 0,      1, 9,  32'h33333333, 1); // 17
        add(0, 1, 4, 1, 10, 32'h44444444,  0, 0, 0,       0, 0,  1, 0, 3'b001, 1, 4, 0,      1, 9,  32'h33333333, 1); // 18 fifo 2, retire valid
        add(1, 1, 5, 1, 11, 32'h55555555,  1, 2, 0,       0, 0,  0, 0, 3'b000, 0, 0, 0,      0, 0,  32'h0,        0); // 19 mid-op reset
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 0, 0,      0, 0,  32'h0,        0); // 20
        add(0, 0, 0, 0, 0, 32'h0,          1, 1, 1,       0, 0,  1, 1, 3'b010, 1, 1, EXC_ON, 0, 0,  32'h0,        2); // 21 exc
        add(0, 0, 0, 0, 0, 32'h0,          1, 2, 0,       0, 0,  1, 1, 3'b010, 1, 2, 0,      0, 0,  32'h0,        2); // 22
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0,       0, 0,  1, 1, 3'b000, 0, 2, 0,      0, 0,  32'h0,        2); // 23

        @(posedge clk); #1;
        foreach (vecs[k]) begin
            drive(vecs[k]);
            #1;
            chk("ready", k, {29'd0, vsldu_rdy, vlsu_rdy, vfu_rdy}, {29'd0, vecs[k].e_rdy});
            @(posedge clk); #1;
            chk("retire_valid", k, {31'd0, ret_v},   {31'd0, vecs[k].e_rv});
            chk("retire_id",    k, {29'd0, ret_id},  {29'd0, vecs[k].e_rid});
            chk("retire_exc",   k, {31'd0, ret_exc}, {31'd0, vecs[k].e_rexc});
            chk("wb_valid",     k, {31'd0, wb_v},    {31'd0, vecs[k].e_wv});
            chk("wb_rd",        k, {27'd0, wb_rd},   {27'd0, vecs[k].e_wrd});
            chk("wb_data",      k, wb_data,          vecs[k].e_wdata);
            chk("rr_q",         k, {30'd0, dut.rr_q}, {30'd0, vecs[k].e_rrq});
        end

        // Reset held for two cycles with all sources requesting: nothing is accepted.
        idle();
        rst = 1'b1; vfu_v = 1'b1; vlsu_v = 1'b1; vsldu_v = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("hold_rst_ready", 100 + c, {29'd0, vsldu_rdy, vlsu_rdy, vfu_rdy}, 32'd0);
            @(posedge clk); #1;
            chk("hold_rst_valid", 100 + c, {30'd0, ret_v, wb_v}, 32'd0);
        end

        // Full FIFO still lets a VFU response without writeback through.
        idle();
        wb_rdy = 1'b0;
        vfu_v = 1'b1; vfu_rsp = '{id: 3'd5, result: 32'hA5A5A5A5, rd: 5'd3, wb: 1'b1};
        #1; chk("fill_a_ready", 110, {31'd0, vfu_rdy}, 32'd1);
        @(posedge clk); #1;
        vfu_rsp = '{id: 3'd6, result: 32'h5A5A5A5A, rd: 5'd4, wb: 1'b1};
        #1; chk("fill_b_ready", 111, {31'd0, vfu_rdy}, 32'd1);
        @(posedge clk); #1;
        vfu_rsp = '{id: 3'd7, result: 32'h0, rd: 5'd0, wb: 1'b0};
        #1; chk("nowb_ready", 112, {31'd0, vfu_rdy}, 32'd1);
        @(posedge clk); #1;
        vfu_v = 1'b0;
        chk("nowb_retire_id", 113, {29'd0, ret_id}, 32'd7);
        chk("nowb_wb_data",   113, wb_data, 32'hA5A5A5A5);
        chk("nowb_wb_rd",     113, {27'd0, wb_rd}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule

// File: doc/spatz_rsp_arbiter.md
# spatz_rsp_arbiter

Completion-side stage directly downstream of the Spatz execution units (VFU, VLSU, VSLDU). It collects their per-instruction responses, which use the `vfu_rsp_t`, `vlsu_rsp_t` and `vsldu_rsp_t` formats of `spatz_pkg`. It retires one instruction ID per cycle towards the controller/scoreboard under round-robin arbitration. Scalar writebacks from the VFU are buffered separately in a small FIFO towards the scalar core's result port.

## Interface
Parameters:
- `WbFifoDepth`, default 2: scalar writeback FIFO entries; legal values are 1 to 4.
- `rsp_vfu_t`, `rsp_vlsu_t`, `rsp_vsldu_t`: default to the `spatz_pkg` types.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: clock. One clock domain only.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `vfu_rsp_valid_i`, in, 1: VFU response valid.
- `vfu_rsp_i`, in, `rsp_vfu_t`: VFU response; fields `id`, `result`, `rd`, `wb`.
- `vfu_rsp_ready_o`, out, 1: VFU response accepted.
- `vlsu_rsp_valid_i`, in, 1: VLSU response valid.
- `vlsu_rsp_i`, in, `rsp_vlsu_t`: VLSU response; fields `id`, `exc`.
- `vlsu_rsp_ready_o`, out, 1: VLSU response accepted.
- `vsldu_rsp_valid_i`, in, 1: VSLDU response valid.
- `vsldu_rsp_i`, in, `rsp_vsldu_t`: VSLDU response; field `id`.
- `vsldu_rsp_ready_o`, out, 1: VSLDU response accepted.
- `retire_valid_o`, out, 1: retire entry valid.
- `retire_id_o`, out, `spatz_id_t`: ID of the retiring instruction.
- `retire_exc_o`, out, 1: retiring instruction raised an exception.
- `retire_ready_i`, in, 1: controller accepts the retire entry.
- `wb_valid_o`, out, 1: scalar writeback valid.
- `wb_data_o`, out, ELEN: writeback data.
- `wb_rd_o`, out, GPRWidth: destination scalar register.
- `wb_ready_i`, in, 1: scalar core accepts the writeback.

## Operation
Sources are indexed VFU=0, VLSU=1, VSLDU=2.

Round-robin arbitration:
- `rr_q` holds 2 bits, encoding 0 to 2.
- Requesters are searched in order `rr_q`, `rr_q+1`, `rr_q+2` (mod 3).
- VFU is eligible only if `vfu_rsp_valid_i` is high and either `wb=0` or the FIFO is not full.
- The first eligible valid source is granted, and only if the retire register can load.
- After a grant, `rr_q` becomes grantee+1 (mod 3). With no grant, `rr_q` holds.

Retire register:
- Single entry {valid, id, exc}.
- Loads when empty or when `retire_ready_i` is high in the same cycle (pipeline register).
- Clears when `retire_ready_i` is high and there is no new grant.

Ready outputs:
- `*_ready_o` is high only for the granted source.
- Each ready is combinational from the valids, FIFO full, `rr_q`, retire state and `retire_ready_i`.
- No ready depends on `wb_ready_i`.

Writeback FIFO:
- Push on VFU grant with `wb=1`, storing {`result`, `rd`}.
- Pop on `wb_valid_o & wb_ready_i`.
- Push and pop in the same cycle are allowed when not full.
- When full, push is blocked even if a pop occurs in the same cycle.
- Read and write pointers wrap modulo `WbFifoDepth`. A count register distinguishes full from empty.
- Output is first-word-fall-through: `wb_valid_o = count != 0`.

Exception flag: `retire_exc_o` is the VLSU `exc` flag for VLSU grants and 0 otherwise (see Configuration).

## Timing
- A response granted in cycle N appears on `retire_*_o` in cycle N+1.
- A writeback granted in cycle N is visible on `wb_*_o` in cycle N+1.
- Sustained throughput: one retire per cycle while `retire_ready_i` stays high.
- Sources must hold valid and payload stable until ready is seen. The block never drops a valid input.
- Reset, including mid-operation: `rr_q=0`, retire register invalid, FIFO count and pointers cleared. All `*_valid_o` and `*_ready_o` are 0 in the cycle after `rst_i` is sampled high, and remain 0 while it stays high. `retire_id_o`, `retire_exc_o`, `wb_data_o` and `wb_rd_o` reset to 0.
- Simultaneous valids from all three sources: grants are serialized over 3 cycles in round-robin order.

## Configuration
Macro `SPATZ_RSP_EXC_EN`:
- Defined: `retire_exc_o` carries the `exc` flag of granted VLSU responses.
- Undefined: `retire_exc_o` is tied to 0, `vlsu_rsp_i.exc` is ignored, and no exception storage bit is synthesized.

## Test plan
- **Single VFU writeback.** After reset, VFU presents {id=2, wb=1, rd=5, result=0xDEADBEEF}. Required: `vfu_rsp_ready_o=1` that cycle; next cycle `retire_id_o=2`, `wb_valid_o=1`, `wb_rd_o=5`, `wb_data_o=0xDEADBEEF`.
- **Round-robin order.** All three sources valid with IDs 0, 1 and 3, `rr_q=0`, `retire_ready_i=1`. Required: retire order is 0, 1, 3 over 3 consecutive cycles, then `rr_q=0`.
- **Retire backpressure.** `retire_ready_i=0` with VLSU id=1 pending. Required: the first response is captured, then all `*_ready_o=0`. `retire_id_o=1` is held stable until `retire_ready_i` rises.
- **FIFO full.** `WbFifoDepth=2`, `wb_ready_i=0`, three VFU wb responses followed by a VSLDU id=3. Required: two VFU responses are accepted; the third is stalled while VSLDU id=3 is granted; after `wb_ready_i=1` for one cycle, the third VFU response is accepted.
- **Reset mid-operation.** FIFO holds 2 entries and the retire register is valid; assert `rst_i` for 1 cycle. Required: `wb_valid_o=0`, `retire_valid_o=0` and `rr_q=0` in the next cycle.
- **Exception flag.** VLSU {id=1, exc=1}. Required: `retire_exc_o=1` with `SPATZ_RSP_EXC_EN` defined, and 0 without it.
